fir_call_driver: RTL and testbench

FIR_CALL_DRIVER -- requirements
Module: fir_call_driver

---
 rtl/fir_call_driver_if.sv | 38 +++
 rtl/fir_call_driver.sv | 127 ++++++++++++
 tb/tb_fir_call_driver.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_call_driver_if.sv
// Handshake bundle between the FIR call driver and its neighbours:
// upstream command, component call/return, downstream result and counters.
interface fir_call_driver_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [63:0]      cmd_d_i;
  logic [63:0]      cmd_idx;
  logic             start;
  logic             busy;
  logic [63:0]      d_i;
  logic [63:0]      idx;
  logic             done;
  logic             stall;
  logic [31:0]      returndata;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [CNT_W-1:0] n_issued;
  logic [CNT_W-1:0] n_returned;

  modport slave (
    input  cmd_valid, cmd_d_i, cmd_idx,
    input  busy, done, returndata, res_ready,
    output cmd_ready, start, d_i, idx,
    output stall, res_valid, res_data,
    output n_issued, n_returned
  );

  modport master (
    output cmd_valid, cmd_d_i, cmd_idx,
    output busy, done, returndata, res_ready,
    input  cmd_ready, start, d_i, idx,
    input  stall, res_valid, res_data,
    input  n_issued, n_returned
  );
endinterface

// File: rtl/fir_call_driver.sv
// Issues FIR component calls from an upstream command stream and
// collects the returns, in call order, into a credit-limited FWFT FIFO.
module fir_call_driver #(
  parameter int RES_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input logic           clock,
  input logic           resetn,
  fir_call_driver_if.slave bus
);

  localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CW = $clog2(RES_DEPTH + 1);
  localparam int UW = CW + 2;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic             r_start;
  logic [63:0]      r_d_i;
  logic [63:0]      r_idx;
  cnt_t             r_inflight;
  cnt_t             r_count;
  ptr_t             r_wr;
  ptr_t             r_rd;
  logic [31:0]      r_mem [RES_DEPTH];
  logic [CNT_W-1:0] r_n_iss;
  logic [CNT_W-1:0] r_n_ret;

  logic [UW-1:0] w_used;
  logic          w_credit;
  logic          w_cmd_ready;
  logic          w_load;
  logic          w_accept;
  logic          w_stall;
  logic          w_push;
  logic          w_valid;
  logic          w_pop;

  function automatic ptr_t f_next(input ptr_t p);
    return (p == ptr_t'(RES_DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // Every slot a result could eventually need is counted: the pending
  // call, the calls out at the component and the results still queued.
  assign w_used = UW'(r_inflight)
                + UW'(r_start)
                + UW'(r_count);

  assign w_credit    = w_used < UW'(RES_DEPTH);
  assign w_cmd_ready = w_credit & (~r_start | ~bus.busy);
  assign w_load      = bus.cmd_valid & w_cmd_ready;
  assign w_accept    = r_start & ~bus.busy;
  assign w_stall     = r_count == cnt_t'(RES_DEPTH);
  assign w_valid     = r_count != '0;
  assign w_pop       = w_valid & bus.res_ready;

  // A return with nothing outstanding is dropped outright.
  assign w_push = bus.done & ~w_stall & (r_inflight != '0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_start <= 1'b0;
      r_d_i   <= '0;
      r_idx   <= '0;
    end else if (w_load) begin
      r_start <= 1'b1;
      r_d_i   <= bus.cmd_d_i;
      r_idx   <= bus.cmd_idx;
    end else if (w_accept) begin
      r_start <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_inflight <= '0;
    end else begin
      unique case ({w_accept, w_push})
        2'b10:   r_inflight <= r_inflight + cnt_t'(1);
        2'b01:   r_inflight <= r_inflight - cnt_t'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + cnt_t'(1);
        2'b01:   r_count <= r_count - cnt_t'(1);
        default: r_count <= r_count;
      endcase
      if (w_push) r_wr <= f_next(r_wr);
      if (w_pop)  r_rd <= f_next(r_rd);
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr] <= bus.returndata;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_n_iss <= '0;
      r_n_ret <= '0;
    end else begin
      if (w_accept) r_n_iss <= r_n_iss + CNT_W'(1);
      if (w_push)   r_n_ret <= r_n_ret + CNT_W'(1);
    end
  end

  assign bus.cmd_ready  = w_cmd_ready;
  assign bus.start      = r_start;
  assign bus.d_i        = r_d_i;
  assign bus.idx        = r_idx;
  assign bus.stall      = w_stall;
  assign bus.res_valid  = w_valid;
  assign bus.res_data   = w_valid ? r_mem[r_rd] : '0;
  assign bus.n_issued   = r_n_iss;
  assign bus.n_returned = r_n_ret;

endmodule

// File: tb/tb_fir_call_driver.sv
// Scoreboard bench for fir_call_driver: a component responder, a
// negedge monitor with a queue-based reference and directed scenarios.
module tb_fir_call_driver;

  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  fir_call_driver_if #(.CNT_W(CW)) bus();

  fir_call_driver #(
    .RES_DEPTH(DEPTH),
    .CNT_W(CW)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .bus(bus)
  );

  typedef struct {
    logic [63:0] d;
    logic [63:0] i;
    logic [31:0] v;
  } cmd_t;

  cmd_t        cmd_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] pend_q[$];

  int total = 0;
  int bad = 0;
  int m_fifo = 0;
  int m_iss = 0;
  int m_ret = 0;
  int m_fired = 0;

  bit          resp_en = 0;
  bit          rand_busy = 0;
  bit          force_busy = 0;
  bit          use_man = 0;
  int          done_pct = 100;
  logic [31:0] man_rd = '0;

  function automatic logic [31:0] f_ret(
    input logic [63:0] d, input logic [63:0] i);
    logic [31:0] a;
    a = d[31:0] ^ i[63:32] ^ (i[31:0] << 3);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      bit   fire, acc, cap, pop;
      cmd_t c;
      @(negedge clock);
      if (!resetn) begin
        cmd_q.delete();
        exp_q.delete();
        pend_q.delete();
        m_fifo = 0;
        m_iss = 0;
        m_ret = 0;
      end else begin
        fire = bus.cmd_valid && bus.cmd_ready;
        acc  = bus.start && !bus.busy;
        cap  = bus.done && (m_fifo != DEPTH)
               && (pend_q.size() > 0);
        pop  = bus.res_valid && bus.res_ready;
        chk("res_valid", bus.res_valid, m_fifo != 0);
        chk("stall", bus.stall, m_fifo == DEPTH);
        chk("credit", exp_q.size() <= DEPTH, 1);
        if (acc) begin
          chk("call_pending", cmd_q.size() != 0, 1);
          if (cmd_q.size() != 0) begin
            c = cmd_q.pop_front();
            chk("call_d_i", bus.d_i, c.d);
            chk("call_idx", bus.idx, c.i);
            pend_q.push_back(c.v);
            m_iss++;
          end
        end
        if (cap) begin
          void'(pend_q.pop_front());
          m_fifo++;
          m_ret++;
        end
        if (pop) begin
          chk("pop_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0)
            chk("res_data", bus.res_data, exp_q.pop_front());
          if (m_fifo > 0) m_fifo--;
        end
        if (fire) begin
          c.d = bus.cmd_d_i;
          c.i = bus.cmd_idx;
          c.v = use_man ? man_rd : f_ret(c.d, c.i);
          cmd_q.push_back(c);
          exp_q.push_back(c.v);
          m_fired++;
        end
      end
    end
  endtask

  task automatic responder();
    forever begin
      @(posedge clock);
      #1;
      bus.busy = rand_busy ? ($urandom_range(0, 3) == 0)
                           : force_busy;
      if (resp_en) begin
        if (pend_q.size() > 0 &&
            $urandom_range(1, 100) <= done_pct) begin
          bus.done = 1'b1;
          bus.returndata = pend_q[0];
        end else begin
          bus.done = 1'b0;
          bus.returndata = $urandom;
        end
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic run_cmds(input int n, input int budget,
                          input bit man, input bit rr_rand,
                          input bit rr_val, output int got);
    int base;
    int last;
    int k;
    base = m_fired;
    last = -1;
    for (int t = 0; t < budget && (m_fired - base) < n; t++) begin
      k = m_fired - base;
      if (k != last) begin
        bus.cmd_d_i = {$urandom, $urandom};
        bus.cmd_idx = {$urandom, $urandom};
        last = k;
      end
      bus.cmd_valid = 1'b1;
      use_man = man;
      man_rd = 32'(k + 1);
      bus.res_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_val;
      cyc(1);
    end
    bus.cmd_valid = 1'b0;
    got = m_fired - base;
  endtask

  task automatic drain();
    int t;
    @(negedge clock);
    resp_en = 1;
    done_pct = 100;
    rand_busy = 0;
    force_busy = 0;
    cyc(1);
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    t = 0;
    while (t < 300 && exp_q.size() != 0) begin
      cyc(1);
      t++;
    end
    chk("drain_left", exp_q.size(), 0);
    @(negedge clock);
    resp_en = 0;
    cyc(1);
    bus.done = 1'b0;
    bus.res_ready = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_d_i"}, bus.d_i, 0);
    chk({nm, "_idx"}, bus.idx, 0);
    chk({nm, "_res_data"}, bus.res_data, 0);
    chk({nm, "_ctl"}, {bus.start, bus.stall, bus.res_valid,
                       bus.n_issued, bus.n_returned}, 0);
  endtask

  initial begin
    int got;
    int prev;
    bus.cmd_valid = 0;
    bus.cmd_d_i = '0;
    bus.cmd_idx = '0;
    bus.busy = 0;
    bus.done = 0;
    bus.returndata = '0;
    bus.res_ready = 0;
    fork
      monitor();
      responder();
    join_none

    cyc(3);
    @(negedge clock);
    chk_zero("reset");

    // single call, first command right after reset release
    cyc(1);
    resetn = 1'b1;
    use_man = 1;
    man_rd = 32'hABCD;
    bus.cmd_d_i = 64'h10;
    bus.cmd_idx = 64'h3;
    bus.cmd_valid = 1'b1;
    @(negedge clock);
    chk("first_ready", bus.cmd_ready, 1);
    cyc(1);
    bus.cmd_valid = 1'b0;
    @(negedge clock);
    chk("single_start", bus.start, 1);
    chk("single_d_i", bus.d_i, 64'h10);
    chk("single_idx", bus.idx, 64'h3);
    cyc(1);
    @(negedge clock);
    chk("single_start_drop", bus.start, 0);
    cyc(2);
    bus.done = 1'b1;
    bus.returndata = 32'hABCD;
    cyc(1);
    bus.done = 1'b0;
    @(negedge clock);
    chk("single_res_valid", bus.res_valid, 1);
    chk("single_res_data", bus.res_data, 32'hABCD);
    cyc(1);
    bus.res_ready = 1'b1;
    cyc(1);
    bus.res_ready = 1'b0;
    @(negedge clock);
    chk("single_n_iss", bus.n_issued, 1);
    chk("single_n_ret", bus.n_returned, 1);

    // busy hold
    force_busy = 1;
    cyc(1);
    man_rd = 32'h77;
    bus.cmd_d_i = 64'h55;
    bus.cmd_idx = 64'h66;
    bus.cmd_valid = 1'b1;
    cyc(1);
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("hold_start", bus.start, 1);
      chk("hold_d_i", bus.d_i, 64'h55);
      chk("hold_idx", bus.idx, 64'h66);
      chk("hold_ready", bus.cmd_ready, 0);
      if (k == 4) force_busy = 0;
      cyc(1);
    end
    @(negedge clock);
    chk("hold_n_iss_pre", bus.n_issued, 1);
    cyc(1);
    @(negedge clock);
    chk("hold_n_iss", bus.n_issued, 2);
    chk("hold_start_drop", bus.start, 0);
    drain();

    // credit limit with a blocked result port
    @(negedge clock);
    resp_en = 1;
    done_pct = 100;
    cyc(1);
    run_cmds(6, 20, 0, 0, 0, got);
    chk("credit_issued", got, 4);
    @(negedge clock);
    chk("credit_ready", bus.cmd_ready, 0);
    chk("credit_stall", bus.stall, 1);
    chk("credit_n_iss", bus.n_issued, 16'(m_iss));
    cyc(1);
    bus.res_ready = 1'b1;
    cyc(1);
    bus.res_ready = 1'b0;
    @(negedge clock);
    chk("credit_stall_pop", bus.stall, 0);
    cyc(1);
    run_cmds(2, 30, 0, 0, 1, got);
    chk("credit_rest", got, 2);
    drain();

    // ordering: results 1..10 under random backpressure
    @(negedge clock);
    resp_en = 1;
    done_pct = 60;
    rand_busy = 1;
    cyc(1);
    run_cmds(10, 300, 1, 1, 0, got);
    chk("order_issued", got, 10);
    drain();

    // random traffic
    @(negedge clock);
    resp_en = 1;
    done_pct = 50;
    rand_busy = 1;
    cyc(1);
    run_cmds(150, 3000, 0, 1, 0, got);
    chk("rand_issued", got, 150);
    drain();
    @(negedge clock);
    chk("rand_n_iss", bus.n_issued, 16'(m_iss));
    chk("rand_n_ret", bus.n_returned, 16'(m_ret));

    // spurious return with nothing outstanding
    prev = m_ret;
    cyc(1);
    bus.done = 1'b1;
    bus.returndata = 32'hDEAD;
    cyc(1);
    bus.done = 1'b0;
    @(negedge clock);
    chk("spur_valid", bus.res_valid, 0);
    chk("spur_n_ret", bus.n_returned, 16'(prev));

    // reset with two calls out and one result queued
    cyc(1);
    run_cmds(3, 20, 0, 0, 0, got);
    chk("rst_setup", got, 3);
    cyc(3);
    bus.done = 1'b1;
    bus.returndata = 32'h1111;
    cyc(1);
    bus.done = 1'b0;
    @(negedge clock);
    chk("rst_pre_valid", bus.res_valid, 1);
    cyc(1);
    resetn = 1'b0;
    @(negedge clock);
    chk_zero("midrst");
    cyc(1);
    resetn = 1'b1;
    cyc(1);
    bus.done = 1'b1;
    bus.returndata = 32'h2222;
    cyc(1);
    bus.done = 1'b0;
    @(negedge clock);
    chk("post_valid", bus.res_valid, 0);
    chk("post_n_ret", bus.n_returned, 0);
    chk("post_n_iss", bus.n_issued, 0);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
